// File: rtl/store_buffer_aligner.sv
// Store buffer: aligns SB/SH/SW stores to word writes, queues them in a FIFO and drains to memory.
// Optional macro STORE_MISALIGN_TRAP_EN traps misaligned SH/SW instead of force-aligning them.

`ifndef FUNCT3_SB
`define FUNCT3_SB 3'b000
`endif
`ifndef FUNCT3_SH
`define FUNCT3_SH 3'b001
`endif
`ifndef FUNCT3_SW
`define FUNCT3_SW 3'b010
`endif

module store_buffer_aligner #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [2:0]       st_funct3,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  input  logic [31:0]      ld_addr,
  output logic             ld_hit,
`ifdef STORE_MISALIGN_TRAP_EN
  output logic             misalign_err,
  output logic [31:0]      misalign_addr,
`endif
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [29:0]      waddr_q [DEPTH];
  logic [31:0]      wdata_q [DEPTH];
  logic [3:0]       be_q    [DEPTH];
  logic [DEPTH-1:0] valid_q;

  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  logic        fmt_ok;
  logic [31:0] al_wdata;
  logic [3:0]  al_be;
  logic [1:0]  b;
  logic        st_fire;
  logic        enq;
  logic        deq;

  assign b = st_addr[1:0];

  always_comb begin
    fmt_ok   = 1'b0;
    al_wdata = st_data;
    al_be    = 4'b0000;
    case (st_funct3)
      `FUNCT3_SB: begin
        fmt_ok   = 1'b1;
        al_wdata = {4{st_data[7:0]}};
        al_be    = 4'b0001 << b;
      end
      `FUNCT3_SH: begin
        fmt_ok   = 1'b1;
        al_wdata = {2{st_data[15:0]}};
        al_be    = b[1] ? 4'b1100 : 4'b0011;
      end
      `FUNCT3_SW: begin
        fmt_ok   = 1'b1;
        al_wdata = st_data;
        al_be    = 4'b1111;
      end
      default: begin
        fmt_ok = 1'b0;
      end
    endcase
  end

  // No bypass: a full buffer refuses stores even while it is dequeuing.
  assign st_ready = (count_q != FULL_CNT);
  assign st_fire  = st_valid && st_ready;
  assign empty    = (count_q == '0);
  assign count    = count_q;

`ifdef STORE_MISALIGN_TRAP_EN
  logic        misaligned;
  logic        mis_fire;
  logic        misalign_err_q;
  logic [31:0] misalign_addr_q;

  assign misaligned = ((st_funct3 == `FUNCT3_SH) && b[0]) ||
                      ((st_funct3 == `FUNCT3_SW) && (b != 2'b00));
  assign mis_fire   = st_fire && misaligned;
  assign enq        = st_fire && fmt_ok && !misaligned;

  always_ff @(posedge clock) begin
    if (reset) begin
      misalign_err_q  <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      misalign_err_q <= mis_fire;
      if (mis_fire) begin
        misalign_addr_q <= st_addr;
      end
    end
  end

  assign misalign_err  = misalign_err_q;
  assign misalign_addr = misalign_addr_q;
`else
  assign enq = st_fire && fmt_ok;
`endif

  assign deq     = mem_valid && mem_ready;
  assign count_d = count_q + CNT_W'(enq) - CNT_W'(deq);

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      if (deq) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
      end
      if (enq) begin
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: valid_q and the empty gating below qualify it.
  always_ff @(posedge clock) begin
    if (enq) begin
      waddr_q[wr_ptr_q] <= st_addr[31:2];
      wdata_q[wr_ptr_q] <= al_wdata;
      be_q[wr_ptr_q]    <= al_be;
    end
  end

  assign mem_valid = !empty;
  assign mem_addr  = empty ? 32'h0 : {waddr_q[rd_ptr_q], 2'b00};
  assign mem_wdata = empty ? 32'h0 : wdata_q[rd_ptr_q];
  assign mem_be    = empty ? 4'h0  : be_q[rd_ptr_q];

  // Word-level match against pending entries; the entry leaving this cycle still counts.
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (waddr_q[i] == ld_addr[31:2])) begin
        ld_hit = 1'b1;
      end
    end
  end

  logic unused_ld_bits;
  assign unused_ld_bits = ^ld_addr[1:0];

endmodule

// File: tb/tb_store_buffer_aligner.sv
// Directed, table-driven bench for store_buffer_aligner in its default build (DEPTH=4).

module tb_store_buffer_aligner;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             clock = 1'b0;
  logic             reset;
  logic             st_valid;
  logic             st_ready;
  logic [2:0]       st_funct3;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic             mem_valid;
  logic             mem_ready;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_be;
  logic [31:0]      ld_addr;
  logic             ld_hit;
  logic [CNT_W-1:0] count;
  logic             empty;

  int checks = 0;
  int errors = 0;

  store_buffer_aligner #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_funct3 (st_funct3),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .ld_addr   (ld_addr),
    .ld_hit    (ld_hit),
    .count     (count),
    .empty     (empty)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_enq;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_store(input logic v, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] d);
    st_valid  = v;
    st_funct3 = f;
    st_addr   = a;
    st_data   = d;
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] a_tmp;

  initial begin
    vecs[0] = '{3'b000, 32'h0000_1002, 32'h0000_00A5, 1'b1, 32'h0000_1000, 32'hA5A5_A5A5, 4'b0100};
    vecs[1] = '{3'b000, 32'h0000_1003, 32'h1122_3344, 1'b1, 32'h0000_1000, 32'h4444_4444, 4'b1000};
    vecs[2] = '{3'b000, 32'h0000_1000, 32'h0000_00FF, 1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'b0001};
    vecs[3] = '{3'b001, 32'h0000_2006, 32'h1234_BEEF, 1'b1, 32'h0000_2004, 32'hBEEF_BEEF, 4'b1100};
    vecs[4] = '{3'b001, 32'h0000_2000, 32'hABCD_5678, 1'b1, 32'h0000_2000, 32'h5678_5678, 4'b0011};
    vecs[5] = '{3'b010, 32'h0000_2008, 32'hCAFE_F00D, 1'b1, 32'h0000_2008, 32'hCAFE_F00D, 4'b1111};
    vecs[6] = '{3'b010, 32'h0000_4001, 32'hDEAD_BEEF, 1'b1, 32'h0000_4000, 32'hDEAD_BEEF, 4'b1111};
    vecs[7] = '{3'b001, 32'h0000_2003, 32'h0000_9876, 1'b1, 32'h0000_2000, 32'h9876_9876, 4'b1100};
    vecs[8] = '{3'b100, 32'h0000_5000, 32'h1234_5678, 1'b0, 32'h0,         32'h0,         4'b0000};
    vecs[9] = '{3'b011, 32'h0000_5004, 32'h1234_5678, 1'b0, 32'h0,         32'h0,         4'b0000};

    reset     = 1'b1;
    mem_ready = 1'b0;
    ld_addr   = 32'h0;
    drive_store(1'b0, 3'b000, 32'h0, 32'h0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    #3;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_st_ready", 32'(st_ready), 32'd1);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_be", 32'(mem_be), 32'h0);
    check("rst_ld_hit", 32'(ld_hit), 32'd0);

    // Alignment table: one store, observe next cycle, then drained.
    mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      drive_store(1'b1, vecs[i].funct3, vecs[i].addr, vecs[i].data);
      #3;
      check($sformatf("v%0d_st_ready", i), 32'(st_ready), 32'd1);
      next_cycle();
      drive_store(1'b0, 3'b000, 32'h0, 32'h0);
      #3;
      check($sformatf("v%0d_mem_valid", i), 32'(mem_valid), 32'(vecs[i].exp_enq));
      check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].exp_enq));
      check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
      check($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].exp_wdata);
      check($sformatf("v%0d_mem_be", i), 32'(mem_be), 32'(vecs[i].exp_be));
      next_cycle();
      #3;
      check($sformatf("v%0d_empty_after", i), 32'(empty), 32'd1);
    end

    // Fill to DEPTH with memory stalled, then drain in order.
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      drive_store(1'b1, 3'b010, 32'h100 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1));
      #3;
      check($sformatf("fill%0d_st_ready", i), 32'(st_ready), 32'd1);
    end
    next_cycle();
    drive_store(1'b1, 3'b010, 32'h200, 32'h5555_5555);
    #3;
    check("full_count", 32'(count), 32'd4);
    check("full_st_ready", 32'(st_ready), 32'd0);
    check("full_head_addr", mem_addr, 32'h100);
    check("full_head_wdata", mem_wdata, 32'h1111_1111);
    next_cycle();
    drive_store(1'b0, 3'b000, 32'h0, 32'h0);
    #3;
    check("full_count_hold", 32'(count), 32'd4);
    check("full_head_stable", mem_addr, 32'h100);
    check("full_be_stable", 32'(mem_be), 32'hF);
    next_cycle();
    mem_ready = 1'b1;
    #3;
    check("drain0_st_ready", 32'(st_ready), 32'd0);
    check("drain0_addr", mem_addr, 32'h100);
    for (int i = 1; i < 4; i++) begin
      next_cycle();
      #3;
      check($sformatf("drain%0d_addr", i), mem_addr, 32'h100 + 32'(4 * i));
      check($sformatf("drain%0d_wdata", i), mem_wdata, 32'h1111_1111 * 32'(i + 1));
      if (i == 1) begin
        check("drain1_st_ready", 32'(st_ready), 32'd1);
        check("drain1_count", 32'(count), 32'd3);
      end
    end
    next_cycle();
    #3;
    check("drain_empty", 32'(empty), 32'd1);

    // Load hit against a pending store.
    mem_ready = 1'b0;
    next_cycle();
    drive_store(1'b1, 3'b010, 32'h3000, 32'h0BAD_F00D);
    ld_addr = 32'h3000;
    #3;
    check("hit_accepting_store", 32'(ld_hit), 32'd0);
    next_cycle();
    drive_store(1'b0, 3'b000, 32'h0, 32'h0);
    ld_addr = 32'h3003;
    #3;
    check("hit_same_word", 32'(ld_hit), 32'd1);
    ld_addr = 32'h3004;
    #1;
    check("hit_next_word", 32'(ld_hit), 32'd0);
    ld_addr = 32'h3000;
    mem_ready = 1'b1;
    #1;
    check("hit_while_dequeue", 32'(ld_hit), 32'd1);
    next_cycle();
    #3;
    check("hit_after_drain", 32'(ld_hit), 32'd0);

    // Steady push+pop at count 2, wrapping pointers; then reset mid-stream.
    mem_ready = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      a_tmp = 32'h500 + 32'(4 * i);
      drive_store(1'b1, 3'b010, a_tmp, a_tmp ^ 32'hA5A5_0000);
      exp_q.push_back(a_tmp);
    end
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      a_tmp = 32'h508 + 32'(4 * k);
      drive_store(1'b1, 3'b010, a_tmp, a_tmp ^ 32'hA5A5_0000);
      mem_ready = 1'b1;
      #3;
      check($sformatf("wrap%0d_count", k), 32'(count), 32'd2);
      check($sformatf("wrap%0d_addr", k), mem_addr, exp_q[0]);
      check($sformatf("wrap%0d_wdata", k), mem_wdata, exp_q[0] ^ 32'hA5A5_0000);
      void'(exp_q.pop_front());
      exp_q.push_back(a_tmp);
    end
    next_cycle();
    reset     = 1'b1;
    mem_ready = 1'b0;
    drive_store(1'b0, 3'b000, 32'h0, 32'h0);
    next_cycle();
    reset = 1'b0;
    #3;
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_mem_valid", 32'(mem_valid), 32'd0);
    check("midrst_mem_addr", mem_addr, 32'h0);
    check("midrst_st_ready", 32'(st_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_buffer_aligner.md
Name: store_buffer_aligner

Overview:
- Store-side counterpart of the load data path.
- Takes store requests (funct3, byte address, register data) from the MEM stage and converts each one to a word-aligned write: replicated write data plus a 4-bit byte-enable.
- Queues the converted writes in a small FIFO and drains them to data memory over a valid/ready handshake.
- Provides a word-address hit flag so the pipeline can stall a load that targets a pending store.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- st_valid  in  1  store request present.
- st_ready  out  1  buffer can accept a store this cycle.
- st_funct3  in  3  store type: `FUNCT3_SB / `FUNCT3_SH / `FUNCT3_SW.
- st_addr  in  32  byte address.
- st_data  in  32  rs2 value; only the low byte or half is used for SB/SH.
- mem_valid  out  1  head entry valid toward memory.
- mem_ready  in  1  memory accepts the head entry.
- mem_addr  out  32  word address of the head entry; bits [1:0] are always 0.
- mem_wdata  out  32  aligned write data.
- mem_be  out  4  byte enables; bit i selects byte lane i.
- ld_addr  in  32  address of the load currently in the MEM stage.
- ld_hit  out  1  combinational; some valid entry has the same word address as ld_addr.
- count  out  CNT_W  occupancy.
- empty  out  1  count == 0.

Behaviour:
- Reset state: rd/wr pointers 0, count 0, empty 1, st_ready 1, mem_valid 0, mem_addr/mem_wdata/mem_be 0, ld_hit 0. Entries still pending when reset is asserted are discarded; nothing is written.
- Acceptance: a store is accepted when st_valid && st_ready.
  - st_ready = (count != DEPTH). There is no bypass: when full, st_ready stays 0 even if the buffer dequeues in the same cycle.
- Alignment by funct3 (b = st_addr[1:0]):
  - SB: wdata = {4{st_data[7:0]}}, be = 4'b0001 << b.
  - SH: wdata = {2{st_data[15:0]}}, be = b[1] ? 4'b1100 : 4'b0011.
  - SW: wdata = st_data, be = 4'b1111.
  - Any other funct3: accepted and consumed (st_ready honoured), but not enqueued; count is unchanged.
- Entry fields: addr = {st_addr[31:2], 2'b00}, plus the aligned wdata and be.
- Latency: a store accepted in cycle N raises mem_valid at the earliest in cycle N+1, when the buffer was empty.
- Drain port:
  - mem_valid = !empty; mem_addr/mem_wdata/mem_be show the head entry.
  - All mem_* outputs are 0 whenever empty.
  - While mem_valid && !mem_ready, mem_* hold stable.
  - The head dequeues on mem_valid && mem_ready.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0. Full and empty are distinguished by count only.
- Order: writes drain in strict FIFO order. No coalescing and no reordering.
- ld_hit: OR over all valid entries of (entry.addr[31:2] == ld_addr[31:2]).
  - Byte enables are ignored; any overlap at word level is a hit.
  - The entry being dequeued this cycle still counts.
  - A store being accepted this cycle does not count.
- Misaligned stores (SH with b[0]=1, SW with b!=0) when the optional feature is disabled:
  - SH uses only b[1]; SW ignores b.
  - The entry is enqueued normally.

Optional Feature:
- Macro: STORE_MISALIGN_TRAP_EN.
- When defined, adds ports misalign_err (out 1) and misalign_addr (out 32).
- A misaligned SH/SW is accepted but not enqueued.
  - In the cycle after acceptance, misalign_err is 1 for exactly one cycle and misalign_addr holds the full st_addr.
  - misalign_addr keeps its value until the next misalignment.
  - Both reset to 0.
- When not defined: the ports are absent and misaligned stores are force-aligned as described in Behaviour.

Test Plan:
- Reset, then SB st_addr=0x1002 st_data=0x000000A5, mem_ready=1 -> next cycle mem_valid=1, mem_addr=0x1000, mem_wdata=0xA5A5A5A5, mem_be=4'b0100; following cycle empty=1.
- SH st_addr=0x2006 st_data=0x1234BEEF -> mem_wdata=0xBEEFBEEF, mem_be=4'b1100; SW at 0x2008 data 0xCAFEF00D -> be=4'b1111, wdata unchanged.
- mem_ready=0, push 4 SWs (DEPTH=4) -> count=4, st_ready=0, head held stable; raise mem_ready -> 4 writes drain in push order; st_ready returns the cycle after the first dequeue.
- Pending SW at 0x3000 with mem_ready=0; ld_addr=0x3003 -> ld_hit=1; ld_addr=0x3004 -> ld_hit=0.
- Count=2, simultaneous push and dequeue for 6 cycles -> count stays 2, pointers wrap, FIFO order preserved; assert reset mid-stream -> next cycle count=0, mem_valid=0.
- STORE_MISALIGN_TRAP_EN defined: SW at 0x4001 -> not enqueued, misalign_err pulses 1 cycle, misalign_addr=0x4001. Undefined: the same store enqueues with mem_addr=0x4000, be=4'b1111.
